// File: rtl/bsram_port_arbiter_if.sv
// Host-side request/acknowledge bundle for the BSRAM port arbiter.
// The save-file loader/dumper drives the request fields and reads back the
// acknowledge pulse and the read data.
//
// Signals:
//   host_req   level request, held until host_ack
//   host_we    1 = write, 0 = read (stable while host_req is high)
//   host_addr  20-bit BSRAM address (stable while host_req is high)
//   host_d     8-bit write data (stable while host_req is high)
//   host_ack   one-cycle completion pulse
//   host_q     registered read data, valid from host_ack onward
//
// Modports: master = host loader side, slave = arbiter side.
interface bsram_port_arbiter_if;
    logic        host_req;
    logic        host_we;
    logic [19:0] host_addr;
    logic [7:0]  host_d;
    logic        host_ack;
    logic [7:0]  host_q;

    modport master (
        output host_req, host_we, host_addr, host_d,
        input  host_ack, host_q
    );

    modport slave (
        input  host_req, host_we, host_addr, host_d,
        output host_ack, host_q
    );
endinterface

// File: rtl/bsram_port_arbiter.sv
// bsram_port_arbiter
// Shares the single cartridge BSRAM port between the active mapper and the
// host save-file loader/dumper. The mapper has absolute priority; host
// accesses fill idle slots and are pre-empted (and retried later) whenever
// the mapper asserts chip enable. A dirty flag tracks mapper writes for
// autosave.
//
// Ports:
//   mclk, rst            clock, synchronous active-high reset
//   bsram_mask           address mask applied to every outgoing address
//   map_addr/map_d       mapper address / write data
//   map_ce_n/oe_n/we_n   mapper strobes, active low
//   map_q                read data to the mapper (combinational from mem_q)
//   host                 host request bundle (slave modport)
//   dirty_clr / dirty    clear pulse / mapper-write flag
//   abort_cnt            saturating count of host pre-emptions
//   mem_addr/mem_d       registered physical port address / write data
//   mem_ce_n/oe_n/we_n   registered physical port strobes, active low
//   mem_q                physical port read data
module bsram_port_arbiter #(
    parameter int HOST_CYC = 2
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic [19:0]          bsram_mask,
    input  logic [19:0]          map_addr,
    input  logic [7:0]           map_d,
    input  logic                 map_ce_n,
    input  logic                 map_oe_n,
    input  logic                 map_we_n,
    output logic [7:0]           map_q,
    bsram_port_arbiter_if.slave  host,
    input  logic                 dirty_clr,
    output logic                 dirty,
    output logic [7:0]           abort_cnt,
    output logic [19:0]          mem_addr,
    output logic [7:0]           mem_d,
    output logic                 mem_ce_n,
    output logic                 mem_oe_n,
    output logic                 mem_we_n,
    input  logic [7:0]           mem_q
);

    localparam logic [3:0] LAST_CNT = 4'(HOST_CYC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOST = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    // Next values (_p0) and their registered copies (_p1)
    logic [19:0] addr_p0, addr_p1;
    logic [7:0]  d_p0, d_p1;
    logic        ce_n_p0, ce_n_p1;
    logic        oe_n_p0, oe_n_p1;
    logic        we_n_p0, we_n_p1;
    logic        ack_p0, ack_p1;
    logic [7:0]  hq_p0, hq_p1;
    logic [7:0]  abort_p0, abort_p1;
    logic        dirty_p0, dirty_p1;

    logic        start;
    logic        last;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A registered ack means the arbiter already returned to IDLE; blocking
    // re-entry on that cycle guarantees one mapper-visible cycle between
    // back-to-back host accesses.
    assign start = host.host_req && map_ce_n && !ack_p1;
    assign last  = (cnt == LAST_CNT);

    // ---- state register ----
    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = HOST;
            HOST:    if (!map_ce_n || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- output logic ----
    always_comb begin
        cnt_nxt  = 4'd0;
        ack_p0   = 1'b0;
        hq_p0    = hq_p1;
        abort_p0 = abort_p1;

        // The port carries the host access exactly in the cycles spent in
        // HOST; every other cycle (including abort and completion turnaround)
        // it carries the mapper.
        if (state_nxt == HOST) begin
            addr_p0 = host.host_addr & bsram_mask;
            d_p0    = host.host_d;
            ce_n_p0 = 1'b0;
            oe_n_p0 = host.host_we;
            we_n_p0 = ~host.host_we;
        end else begin
            addr_p0 = map_addr & bsram_mask;
            d_p0    = map_d;
            ce_n_p0 = map_ce_n;
            oe_n_p0 = map_oe_n;
            we_n_p0 = map_we_n;
        end

        if (state == HOST) begin
            cnt_nxt = cnt + 4'd1;
            if (!map_ce_n) begin
                abort_p0 = sat_inc8(abort_p1);
            end else if (last) begin
                ack_p0 = 1'b1;
                if (!host.host_we) hq_p0 = mem_q;
            end
        end

        // Set beats clear when a mapper write and dirty_clr coincide.
        if (!map_ce_n && !map_we_n) dirty_p0 = 1'b1;
        else if (dirty_clr)         dirty_p0 = 1'b0;
        else                        dirty_p0 = dirty_p1;
    end

    // ---- output registers ----
    always_ff @(posedge mclk) begin
        if (rst) begin
            addr_p1  <= 20'd0;
            d_p1     <= 8'd0;
            ce_n_p1  <= 1'b1;
            oe_n_p1  <= 1'b1;
            we_n_p1  <= 1'b1;
            ack_p1   <= 1'b0;
            hq_p1    <= 8'd0;
            abort_p1 <= 8'd0;
            dirty_p1 <= 1'b0;
        end else begin
            addr_p1  <= addr_p0;
            d_p1     <= d_p0;
            ce_n_p1  <= ce_n_p0;
            oe_n_p1  <= oe_n_p0;
            we_n_p1  <= we_n_p0;
            ack_p1   <= ack_p0;
            hq_p1    <= hq_p0;
            abort_p1 <= abort_p0;
            dirty_p1 <= dirty_p0;
        end
    end

    assign mem_addr      = addr_p1;
    assign mem_d         = d_p1;
    assign mem_ce_n      = ce_n_p1;
    assign mem_oe_n      = oe_n_p1;
    assign mem_we_n      = we_n_p1;
    assign host.host_ack = ack_p1;
    assign host.host_q   = hq_p1;
    assign abort_cnt     = abort_p1;
    assign dirty         = dirty_p1;
    assign map_q         = mem_q;

endmodule

// File: tb/tb_bsram_port_arbiter.sv
module tb_bsram_port_arbiter;

    logic        mclk;
    logic        rst;
    logic [19:0] bsram_mask;
    logic [19:0] map_addr;
    logic [7:0]  map_d;
    logic        map_ce_n, map_oe_n, map_we_n;
    logic [7:0]  map_q;
    logic        dirty_clr;
    logic        dirty;
    logic [7:0]  abort_cnt;
    logic [19:0] mem_addr;
    logic [7:0]  mem_d;
    logic        mem_ce_n, mem_oe_n, mem_we_n;
    logic [7:0]  mem_q;

    int n_assert = 0;
    int n_fail   = 0;

    bsram_port_arbiter_if hif ();

    bsram_port_arbiter #(.HOST_CYC(2)) dut (
        .mclk       (mclk),
        .rst        (rst),
        .bsram_mask (bsram_mask),
        .map_addr   (map_addr),
        .map_d      (map_d),
        .map_ce_n   (map_ce_n),
        .map_oe_n   (map_oe_n),
        .map_we_n   (map_we_n),
        .map_q      (map_q),
        .host       (hif),
        .dirty_clr  (dirty_clr),
        .dirty      (dirty),
        .abort_cnt  (abort_cnt),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_ce_n   (mem_ce_n),
        .mem_oe_n   (mem_oe_n),
        .mem_we_n   (mem_we_n),
        .mem_q      (mem_q)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Behavioural BSRAM: combinational read, write at the clock edge.
    // Reset preloads the two locations the host reads.
    logic [7:0] mem [0:(1<<20)-1];
    always @(posedge mclk) begin
        if (rst) begin
            mem[20'h00123] <= 8'hA5;
            mem[20'h00456] <= 8'h5A;
        end else if (!mem_ce_n && !mem_we_n) begin
            mem[mem_addr] <= mem_d;
        end
    end
    assign mem_q = (!mem_ce_n && !mem_oe_n) ? mem[mem_addr] : 8'h00;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic map_idle();
        map_ce_n = 1'b1;
        map_oe_n = 1'b1;
        map_we_n = 1'b1;
    endtask

    logic ack_seen;

    initial begin
        // ---------------- reset with arbitrary inputs ----------------
        rst           = 1'b1;
        bsram_mask    = 20'hFFFFF;
        map_addr      = 20'h5A5A5;
        map_d         = 8'h99;
        map_ce_n      = 1'b0;
        map_oe_n      = 1'b1;
        map_we_n      = 1'b0;
        dirty_clr     = 1'b0;
        hif.host_req  = 1'b1;
        hif.host_we   = 1'b1;
        hif.host_addr = 20'h00321;
        hif.host_d    = 8'h42;
        tick();
        tick();
        chk("rst_ce_n",  32'(mem_ce_n), 1);
        chk("rst_oe_n",  32'(mem_oe_n), 1);
        chk("rst_we_n",  32'(mem_we_n), 1);
        chk("rst_addr",  32'(mem_addr), 0);
        chk("rst_d",     32'(mem_d), 0);
        chk("rst_ack",   32'(hif.host_ack), 0);
        chk("rst_q",     32'(hif.host_q), 0);
        chk("rst_dirty", 32'(dirty), 0);
        chk("rst_abort", 32'(abort_cnt), 0);

        rst          = 1'b0;
        map_idle();
        map_addr     = 20'h0;
        map_d        = 8'h0;
        hif.host_req = 1'b0;
        bsram_mask   = 20'h01FFF;
        tick();
        chk("idle_ce_n", 32'(mem_ce_n), 1);

        // ---------------- host read, idle mapper ----------------
        hif.host_req  = 1'b1;
        hif.host_we   = 1'b0;
        hif.host_addr = 20'h00123;
        tick();
        chk("rd_c1_addr", 32'(mem_addr), 32'h00123);
        chk("rd_c1_oe",   32'(mem_oe_n), 0);
        chk("rd_c1_ce",   32'(mem_ce_n), 0);
        chk("rd_c1_we",   32'(mem_we_n), 1);
        chk("rd_c1_ack",  32'(hif.host_ack), 0);
        tick();
        chk("rd_c2_addr", 32'(mem_addr), 32'h00123);
        chk("rd_c2_oe",   32'(mem_oe_n), 0);
        chk("rd_c2_ack",  32'(hif.host_ack), 0);
        tick();
        chk("rd_ack",     32'(hif.host_ack), 1);
        chk("rd_q",       32'(hif.host_q), 32'hA5);
        chk("rd_dirty",   32'(dirty), 0);
        chk("rd_rel_ce",  32'(mem_ce_n), 1);
        hif.host_req = 1'b0;
        tick();
        chk("rd_ack_pulse", 32'(hif.host_ack), 0);
        chk("rd_q_hold",    32'(hif.host_q), 32'hA5);

        // ---------------- pre-emption of a host write ----------------
        hif.host_req  = 1'b1;
        hif.host_we   = 1'b1;
        hif.host_addr = 20'h00010;
        hif.host_d    = 8'h3C;
        tick();
        chk("wr_we",   32'(mem_we_n), 0);
        chk("wr_d",    32'(mem_d), 32'h3C);
        chk("wr_addr", 32'(mem_addr), 32'h00010);
        tick();
        // second HOST cycle: mapper read arrives on the would-be completion
        map_ce_n = 1'b0;
        map_oe_n = 1'b0;
        map_addr = 20'h00200;
        map_d    = 8'hEE;
        tick();
        chk("pre_addr",  32'(mem_addr), 32'h00200);
        chk("pre_oe",    32'(mem_oe_n), 0);
        chk("pre_we",    32'(mem_we_n), 1);
        chk("pre_d",     32'(mem_d), 32'hEE);
        chk("pre_abort", 32'(abort_cnt), 1);
        chk("pre_noack", 32'(hif.host_ack), 0);
        map_idle();
        tick();
        chk("retry_we",   32'(mem_we_n), 0);
        chk("retry_addr", 32'(mem_addr), 32'h00010);
        tick();
        chk("retry_noack", 32'(hif.host_ack), 0);
        tick();
        chk("retry_ack",   32'(hif.host_ack), 1);
        chk("retry_abort", 32'(abort_cnt), 1);
        chk("retry_dirty", 32'(dirty), 0);
        chk("retry_mem",   32'(mem[20'h00010]), 32'h3C);
        hif.host_req = 1'b0;
        tick();

        // ---------------- mapper write and dirty handling ----------------
        bsram_mask = 20'h07FFF;
        map_ce_n   = 1'b0;
        map_we_n   = 1'b0;
        map_addr   = 20'h1FFFF;
        map_d      = 8'h77;
        tick();
        chk("mw_addr",  32'(mem_addr), 32'h07FFF);
        chk("mw_d",     32'(mem_d), 32'h77);
        chk("mw_we",    32'(mem_we_n), 0);
        chk("mw_dirty", 32'(dirty), 1);
        dirty_clr = 1'b1;
        tick();
        chk("mw_setwins", 32'(dirty), 1);
        chk("mw_mem",     32'(mem[20'h07FFF]), 32'h77);
        map_idle();
        tick();
        chk("mw_clr", 32'(dirty), 0);
        dirty_clr = 1'b0;

        // ---------------- collision: mapper wins ----------------
        bsram_mask    = 20'h01FFF;
        hif.host_req  = 1'b1;
        hif.host_we   = 1'b0;
        hif.host_addr = 20'h00456;
        hif.host_d    = 8'h11;
        map_ce_n      = 1'b0;
        map_oe_n      = 1'b0;
        map_addr      = 20'h00050;
        map_d         = 8'h22;
        tick();
        chk("col_addr", 32'(mem_addr), 32'h00050);
        chk("col_d",    32'(mem_d), 32'h22);
        chk("col_oe",   32'(mem_oe_n), 0);
        tick();
        chk("col_hold", 32'(mem_addr), 32'h00050);
        chk("col_ack",  32'(hif.host_ack), 0);
        map_idle();
        tick();
        chk("col_host_addr", 32'(mem_addr), 32'h00456);
        chk("col_host_d",    32'(mem_d), 32'h11);
        tick();
        tick();
        chk("col_ack2", 32'(hif.host_ack), 1);
        chk("col_q",    32'(hif.host_q), 32'h5A);

        // ---------------- back-to-back: request held through ack ----------------
        tick();
        chk("b2b_gap_ce",  32'(mem_ce_n), 1);
        chk("b2b_gap_ack", 32'(hif.host_ack), 0);
        tick();
        chk("b2b_reenter", 32'(mem_ce_n), 0);
        tick();
        tick();
        chk("b2b_ack", 32'(hif.host_ack), 1);
        hif.host_req = 1'b0;
        tick();

        // ---------------- abort saturation ----------------
        hif.host_req  = 1'b1;
        hif.host_we   = 1'b0;
        hif.host_addr = 20'h00123;
        ack_seen      = 1'b0;
        for (int i = 0; i < 300; i++) begin
            map_ce_n = 1'b1;
            tick();
            if (hif.host_ack) ack_seen = 1'b1;
            map_ce_n = 1'b0;
            tick();
            if (hif.host_ack) ack_seen = 1'b1;
            if (i == 252) chk("sat_254", 32'(abort_cnt), 254);
            if (i == 253) chk("sat_255", 32'(abort_cnt), 255);
        end
        chk("sat_final", 32'(abort_cnt), 255);
        chk("sat_noack", 32'(ack_seen), 0);

        // ---------------- reset during HOST ----------------
        map_ce_n = 1'b1;
        tick();
        chk("mid_in_host", 32'(mem_ce_n), 0);
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        hif.host_req = 1'b0;
        chk("mid_ce",    32'(mem_ce_n), 1);
        chk("mid_oe",    32'(mem_oe_n), 1);
        chk("mid_we",    32'(mem_we_n), 1);
        chk("mid_addr",  32'(mem_addr), 0);
        chk("mid_d",     32'(mem_d), 0);
        chk("mid_ack",   32'(hif.host_ack), 0);
        chk("mid_q",     32'(hif.host_q), 0);
        chk("mid_abort", 32'(abort_cnt), 0);
        chk("mid_dirty", 32'(dirty), 0);
        tick();
        chk("mid_dropped", 32'(hif.host_ack), 0);
        tick();
        chk("mid_dropped2", 32'(hif.host_ack), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
